// File: rtl/timer_seq_ctrl.sv
// rtl/timer_seq_ctrl.sv - round-robin sequencer sharing one interval timer among one-shot delay requesters (optional cancel: TIMER_SEQ_CANCEL_EN)
module timer_seq_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  delay,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic [ID_W-1:0]        active_id,
    output logic [2:0]             tmr_address,
    output logic                   tmr_chipselect,
    output logic                   tmr_write_n,
    output logic [15:0]            tmr_writedata,
    input  logic                   tmr_irq
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_PL    = 3'd1;
    localparam logic [2:0] S_WR_PH    = 3'd2;
    localparam logic [2:0] S_WR_CTRL  = 3'd3;
    localparam logic [2:0] S_WAIT_IRQ = 3'd4;
    localparam logic [2:0] S_WR_STOP  = 3'd5;
    localparam logic [2:0] S_WR_CLR   = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [2:0]  ADDR_STATUS = 3'd0;
    localparam logic [2:0]  ADDR_CTRL   = 3'd1;
    localparam logic [2:0]  ADDR_PL     = 3'd2;
    localparam logic [2:0]  ADDR_PH     = 3'd3;
    localparam logic [15:0] CTRL_START  = 16'h0005;
    localparam logic [15:0] CTRL_STOP   = 16'h0008;

    logic [2:0]      state;
    logic [2:0]      state_nx;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] grant_id;
    logic            grant_vld;
    logic [31:0]     dly_sel;
    logic [31:0]     dly_clamp;
    logic [15:0]     period_hi;
    logic            cancel;
    logic            aborted;

    logic            cs_nx;
    logic            wn_nx;
    logic [2:0]      addr_nx;
    logic [15:0]     data_nx;

    // Round-robin search: the offset closest to last_grant+1 wins, last_grant itself is checked last
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = last_grant;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last_grant) + k) % NUM_REQ]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

    // Winning requester's period; zero would never fire, so it is raised to one
    always_comb begin
        dly_sel   = delay[32*int'(grant_id) +: 32];
        dly_clamp = (dly_sel == 32'd0) ? 32'd1 : dly_sel;
    end

    // Cancellation request from the granted requester (constant low when the feature is built out)
    always_comb begin
        cancel = 1'b0;
`ifdef TIMER_SEQ_CANCEL_EN
        if ((state == S_WR_PL) || (state == S_WR_PH) || (state == S_WR_CTRL) || (state == S_WAIT_IRQ))
            cancel = !req[active_id];
`endif
    end

    // Next-state logic; cancel takes priority over an irq seen in the same cycle
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     state_nx = grant_vld ? S_WR_PL : S_IDLE;
            S_WR_PL:    state_nx = cancel ? S_WR_STOP : S_WR_PH;
            S_WR_PH:    state_nx = cancel ? S_WR_STOP : S_WR_CTRL;
            S_WR_CTRL:  state_nx = cancel ? S_WR_STOP : S_WAIT_IRQ;
            S_WAIT_IRQ: begin
                if (cancel)
                    state_nx = S_WR_STOP;
                else if (tmr_irq)
                    state_nx = S_WR_CLR;
            end
`ifdef TIMER_SEQ_CANCEL_EN
            S_WR_STOP:  state_nx = S_WR_CLR;
`endif
            S_WR_CLR:   state_nx = aborted ? S_IDLE : S_DONE;
            S_DONE:     state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // Bus values for the state being entered, so the registered outputs line up with the state
    always_comb begin
        cs_nx   = 1'b0;
        wn_nx   = 1'b1;
        addr_nx = 3'd0;
        data_nx = 16'h0000;
        case (state_nx)
            S_WR_PL: begin
                cs_nx = 1'b1; wn_nx = 1'b0; addr_nx = ADDR_PL;   data_nx = dly_clamp[15:0];
            end
            S_WR_PH: begin
                cs_nx = 1'b1; wn_nx = 1'b0; addr_nx = ADDR_PH;   data_nx = period_hi;
            end
            S_WR_CTRL: begin
                cs_nx = 1'b1; wn_nx = 1'b0; addr_nx = ADDR_CTRL; data_nx = CTRL_START;
            end
            S_WR_STOP: begin
                cs_nx = 1'b1; wn_nx = 1'b0; addr_nx = ADDR_CTRL; data_nx = CTRL_STOP;
            end
            S_WR_CLR: begin
                cs_nx = 1'b1; wn_nx = 1'b0; addr_nx = ADDR_STATUS; data_nx = 16'h0000;
            end
            default: begin
                cs_nx   = 1'b0;
                wn_nx   = 1'b1;
                addr_nx = 3'd0;
                data_nx = 16'h0000;
            end
        endcase
    end

    // State, grant bookkeeping and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            last_grant     <= ID_W'(NUM_REQ - 1);
            active_id      <= '0;
            period_hi      <= 16'h0000;
            aborted        <= 1'b0;
            busy           <= 1'b0;
            done           <= '0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_address    <= 3'd0;
            tmr_writedata  <= 16'h0000;
        end else begin
            state          <= state_nx;
            busy           <= (state_nx != S_IDLE);
            done           <= (state_nx == S_DONE) ? (NUM_REQ'(1) << active_id) : '0;
            tmr_chipselect <= cs_nx;
            tmr_write_n    <= wn_nx;
            tmr_address    <= addr_nx;
            tmr_writedata  <= data_nx;

            if (state == S_IDLE && grant_vld) begin
                active_id <= grant_id;
                period_hi <= dly_clamp[31:16];
            end

            // Completed or cancelled, the requester just served moves to lowest priority
            if (state != S_IDLE && state_nx == S_IDLE)
                last_grant <= active_id;

            if (state_nx == S_WR_STOP)
                aborted <= 1'b1;
            else if (state == S_IDLE)
                aborted <= 1'b0;
        end
    end

endmodule
